regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised integer register file for the decode/writeback stages: NRD async read
//  ports, NWR sync write ports, x0 hardwired to zero, optional write-to-read bypass.
//  Integrated scoreboard holds one pending bit per register, set at issue and cleared
//  at writeback; decode uses it for RAW/WAW stall decisions. Pending-count output exposed.
// PARAMETERS
//  XLEN    64  register width (bits)
//  NREG    32  number of registers (power of 2, >=2); AW = $clog2(NREG)
//  NRD     2   read ports
//  NWR     1   write ports
//  BYPASS  1   1: reads see same-cycle write data; 0: reads see stored value only
// PORTS
//  clk_sys_i    in   1         system clock, all state on posedge
//  rst_sys_n_i  in   1         async active-low reset
//  rd_addr_i    in   NRD*AW    read addresses, port p at [p*AW +: AW]
//  rd_data_o    out  NRD*XLEN  read data, port p at [p*XLEN +: XLEN]
//  rd_busy_o    out  NRD       pending bit of rd_addr for port p (after bypass rule)
//  wr_en_i      in   NWR       write enables
//  wr_addr_i    in   NWR*AW    write addresses
//  wr_data_i    in   NWR*XLEN  write data
//  iss_en_i     in   1         issue request: mark iss_addr_i pending
//  iss_addr_i   in   AW        destination register of issued instruction
//  iss_ready_o  out  1         issue accepted this cycle if iss_en_i high
//  pend_cnt_o   out  AW+1      number of registers currently pending (registered)
// BEHAVIOUR
//  Reset (async assert, sync-to-clock deassert outside block): all registers 0, all
//   pending bits 0, pend_cnt_o 0. Outputs are combinational from state, so post-reset
//   rd_data_o=0, rd_busy_o=0, iss_ready_o=1.
//  Write: at posedge, for each port w with wr_en_i[w] and wr_addr!=0, reg<=wr_data.
//   Multiple ports same addr same cycle: highest port index wins. Writes to x0 dropped.
//  Read: combinational. addr 0 -> 0, busy 0. BYPASS=1 and a write enabled to the same
//   nonzero addr this cycle -> wr_data of highest such port, busy=0. Otherwise stored
//   value and stored pending bit. BYPASS=0: stored value, stored pending bit.
//  Scoreboard: any enabled write to addr a clears pending[a] at posedge (write
//   enable alone clears; no tag check). Issue accepted when iss_en_i & iss_ready_o:
//   sets pending[iss_addr] at posedge. Same-cycle write-clear and accepted issue to same
//   addr: set wins (new producer outstanding). iss_addr=0: accepted, no bit set.
//  iss_ready_o = (iss_addr_i==0) | ~pending[iss_addr_i] | (write to iss_addr_i this
//   cycle). Low -> WAW stall; iss_en_i while low is ignored, no state change.
//  pend_cnt_o: registered popcount of pending bits, updated each posedge as
//   count + set - clears; never wraps (max NREG-1 since x0 never pending).
//  Reset asserted mid-operation: in-flight writes and issues lost, state cleared at once.
//  Latency: write -> visible in stored state next cycle; bypassed same cycle.
// TESTING
//  1 reset, read all ports addr 1..NREG-1 -> data 0, busy 0, pend_cnt_o=0, iss_ready_o=1.
//  2 write x5=0xDEAD_BEEF; next cycle read x5 -> 0xDEADBEEF; write x0=0x1234 -> x0 reads 0.
//  3 BYPASS=1: write x7=0xA5 while reading x7 same cycle -> rd_data 0xA5, busy 0;
//    BYPASS=0 build -> old value 0.
//  4 issue x3 -> pending; next cycle rd_busy for x3=1, pend_cnt_o=1, iss x3 again ->
//    iss_ready_o=0, no change; write x3 -> busy clears, pend_cnt_o=0.
//  5 same cycle: write x9 (pending) and issue x9 -> x9 still pending, count unchanged;
//    NWR=2 both ports write x4 (0x11 port0, 0x22 port1) -> x4 reads 0x22.
//  6 issue x1..x31 back-to-back -> pend_cnt_o=31; assert rst_sys_n_i low mid-cycle ->
//    count 0, all busy 0 immediately without a clock edge.

Source files
------------

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_sb
// Brief    : Multi-port integer register file (x0 = 0) with optional
//            write-to-read bypass and a per-register pending scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_sb #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk_sys_i,
    input  logic                rst_sys_n_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    output logic                iss_ready_o,
    output logic [AW:0]         pend_cnt_o
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_pend;
    logic [AW:0]     r_pend_cnt;

    logic [NREG-1:0] w_clr;
    logic            w_iss_wr_hit;
    logic            w_iss_ready;
    logic [NREG-1:0] w_pend_nxt;
    logic [AW:0]     w_cnt_nxt;

    // Scoreboard next state: clears from every enabled write, then an
    // accepted issue sets its bit so a fresh producer is never lost.
    always_comb begin
        w_clr        = '0;
        w_iss_wr_hit = 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en_i[w]) begin
                w_clr[wr_addr_i[w*AW +: AW]] = 1'b1;
                if (wr_addr_i[w*AW +: AW] == iss_addr_i)
                    w_iss_wr_hit = 1'b1;
            end
        end
        w_iss_ready = (iss_addr_i == '0) || !r_pend[iss_addr_i] || w_iss_wr_hit;
        w_pend_nxt  = r_pend & ~w_clr;
        if (iss_en_i && w_iss_ready && (iss_addr_i != '0))
            w_pend_nxt[iss_addr_i] = 1'b1;
        w_pend_nxt[0] = 1'b0;
        w_cnt_nxt = '0;
        for (int i = 0; i < NREG; i++)
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_pend_nxt[i]);
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_n_i) begin
        if (!rst_sys_n_i) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            // Later iterations override earlier ones: highest port wins.
            for (int w = 0; w < NWR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0))
                    r_regs[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
            end
            r_pend     <= w_pend_nxt;
            r_pend_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_data_o[p*XLEN +: XLEN] = r_regs[rd_addr_i[p*AW +: AW]];
            rd_busy_o[p]              = r_pend[rd_addr_i[p*AW +: AW]];
            if (BYPASS != 0) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == rd_addr_i[p*AW +: AW])) begin
                        rd_data_o[p*XLEN +: XLEN] = wr_data_i[w*XLEN +: XLEN];
                        rd_busy_o[p]              = 1'b0;
                    end
                end
            end
            if (rd_addr_i[p*AW +: AW] == '0) begin
                rd_data_o[p*XLEN +: XLEN] = '0;
                rd_busy_o[p]              = 1'b0;
            end
        end
    end

    assign iss_ready_o = w_iss_ready;
    assign pend_cnt_o  = r_pend_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp_sb
// Brief    : Directed self-checking bench; bypass and non-bypass instances
//            share every input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_sb;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk_sys_i;
    logic                rst_sys_n_i;
    logic [NRD*AW-1:0]   rd_addr_i;
    logic [NWR-1:0]      wr_en_i;
    logic [NWR*AW-1:0]   wr_addr_i;
    logic [NWR*XLEN-1:0] wr_data_i;
    logic                iss_en_i;
    logic [AW-1:0]       iss_addr_i;

    logic [NRD*XLEN-1:0] w_rd_data_b, w_rd_data_n;
    logic [NRD-1:0]      w_rd_busy_b, w_rd_busy_n;
    logic                w_iss_ready_b, w_iss_ready_n;
    logic [AW:0]         w_cnt_b, w_cnt_n;

    int n_chk = 0;
    int n_err = 0;

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
        .clk_sys_i(clk_sys_i), .rst_sys_n_i(rst_sys_n_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(w_rd_data_b), .rd_busy_o(w_rd_busy_b),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .iss_en_i(iss_en_i), .iss_addr_i(iss_addr_i),
        .iss_ready_o(w_iss_ready_b), .pend_cnt_o(w_cnt_b)
    );

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
        .clk_sys_i(clk_sys_i), .rst_sys_n_i(rst_sys_n_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(w_rd_data_n), .rd_busy_o(w_rd_busy_n),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .iss_en_i(iss_en_i), .iss_addr_i(iss_addr_i),
        .iss_ready_o(w_iss_ready_n), .pend_cnt_o(w_cnt_n)
    );

    initial clk_sys_i = 1'b0;
    always #5 clk_sys_i = ~clk_sys_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys_i);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr_i[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int w, input logic en, input logic [AW-1:0] a,
                          input logic [XLEN-1:0] d);
        wr_en_i[w]                 = en;
        wr_addr_i[w*AW +: AW]      = a;
        wr_data_i[w*XLEN +: XLEN]  = d;
    endtask

    function automatic logic [63:0] rdb(input int p);
        return w_rd_data_b[p*XLEN +: XLEN];
    endfunction

    function automatic logic [63:0] rdn(input int p);
        return w_rd_data_n[p*XLEN +: XLEN];
    endfunction

    initial begin
        rst_sys_n_i = 1'b0;
        rd_addr_i   = '0;
        wr_en_i     = '0;
        wr_addr_i   = '0;
        wr_data_i   = '0;
        iss_en_i    = 1'b0;
        iss_addr_i  = '0;

        // 1: reset state
        #12;
        chk("rst_cnt", 64'(w_cnt_b), 64'd0);
        rst_sys_n_i = 1'b1;
        for (int a = 1; a < NREG; a++) begin
            set_rd(0, AW'(a));
            set_rd(1, AW'(a));
            iss_addr_i = AW'(a);
            #1;
            chk("rst_rd0", rdb(0), 64'd0);
            chk("rst_rd1", rdb(1), 64'd0);
            chk("rst_busy", 64'(w_rd_busy_b), 64'd0);
            chk("rst_ready", 64'(w_iss_ready_b), 64'd1);
        end
        chk("rst_cnt2", 64'(w_cnt_b), 64'd0);
        iss_addr_i = '0;

        // 2: plain write, then x0 write dropped
        step();
        set_wr(0, 1'b1, 5'd5, 64'hDEAD_BEEF);
        step();
        set_wr(0, 1'b0, 5'd0, 64'd0);
        set_rd(0, 5'd5);
        #1;
        chk("wr_x5_b", rdb(0), 64'hDEAD_BEEF);
        chk("wr_x5_n", rdn(0), 64'hDEAD_BEEF);
        set_wr(0, 1'b1, 5'd0, 64'h1234);
        set_rd(1, 5'd0);
        #1;
        chk("x0_same_cyc", rdb(1), 64'd0);
        step();
        set_wr(0, 1'b0, 5'd0, 64'd0);
        #1;
        chk("x0_after", rdb(1), 64'd0);

        // 3: bypass vs stored value
        set_wr(0, 1'b1, 5'd7, 64'hA5);
        set_rd(1, 5'd7);
        #1;
        chk("byp_data", rdb(1), 64'hA5);
        chk("byp_busy", 64'(w_rd_busy_b[1]), 64'd0);
        chk("nobyp_data", rdn(1), 64'd0);
        step();
        set_wr(0, 1'b0, 5'd0, 64'd0);
        #1;
        chk("x7_b", rdb(1), 64'hA5);
        chk("x7_n", rdn(1), 64'hA5);

        // 4: issue, WAW stall, writeback clear
        iss_en_i   = 1'b1;
        iss_addr_i = 5'd3;
        #1;
        chk("iss3_ready", 64'(w_iss_ready_b), 64'd1);
        step();
        iss_en_i = 1'b0;
        set_rd(0, 5'd3);
        #1;
        chk("x3_busy", 64'(w_rd_busy_b[0]), 64'd1);
        chk("cnt1", 64'(w_cnt_b), 64'd1);
        iss_en_i = 1'b1;
        #1;
        chk("iss3_stall", 64'(w_iss_ready_b), 64'd0);
        step();
        iss_en_i = 1'b0;
        #1;
        chk("stall_cnt", 64'(w_cnt_b), 64'd1);
        chk("stall_busy", 64'(w_rd_busy_b[0]), 64'd1);
        set_wr(0, 1'b1, 5'd3, 64'h33);
        #1;
        chk("wb_ready", 64'(w_iss_ready_b), 64'd1);
        chk("wb_busy_b", 64'(w_rd_busy_b[0]), 64'd0);
        chk("wb_busy_n", 64'(w_rd_busy_n[0]), 64'd1);
        step();
        set_wr(0, 1'b0, 5'd0, 64'd0);
        #1;
        chk("x3_clr_busy", 64'(w_rd_busy_n[0]), 64'd0);
        chk("x3_clr_cnt", 64'(w_cnt_b), 64'd0);
        chk("x3_data", rdn(0), 64'h33);

        // 5: set beats clear; dual-port same address
        iss_en_i   = 1'b1;
        iss_addr_i = 5'd9;
        step();
        set_wr(0, 1'b1, 5'd9, 64'h99);
        #1;
        chk("x9_ready", 64'(w_iss_ready_b), 64'd1);
        step();
        iss_en_i = 1'b0;
        set_wr(0, 1'b0, 5'd0, 64'd0);
        set_rd(0, 5'd9);
        #1;
        chk("x9_busy", 64'(w_rd_busy_b[0]), 64'd1);
        chk("x9_cnt", 64'(w_cnt_b), 64'd1);
        set_wr(0, 1'b1, 5'd9, 64'h98);
        step();
        set_wr(0, 1'b1, 5'd4, 64'h11);
        set_wr(1, 1'b1, 5'd4, 64'h22);
        set_rd(0, 5'd4);
        #1;
        chk("x9_clr_cnt", 64'(w_cnt_b), 64'd0);
        chk("x4_byp", rdb(0), 64'h22);
        step();
        set_wr(0, 1'b0, 5'd0, 64'd0);
        set_wr(1, 1'b0, 5'd0, 64'd0);
        #1;
        chk("x4_b", rdb(0), 64'h22);
        chk("x4_n", rdn(0), 64'h22);

        // 6: fill scoreboard, then asynchronous reset mid-cycle
        iss_en_i = 1'b1;
        for (int a = 1; a < NREG; a++) begin
            iss_addr_i = AW'(a);
            step();
        end
        iss_en_i = 1'b0;
        set_rd(0, 5'd1);
        set_rd(1, 5'd31);
        #1;
        chk("full_cnt", 64'(w_cnt_b), 64'd31);
        chk("full_busy", 64'(w_rd_busy_b), 64'd3);
        iss_addr_i = 5'd17;
        #1;
        chk("full_stall", 64'(w_iss_ready_b), 64'd0);
        set_rd(0, 5'd5);
        #1;
        rst_sys_n_i = 1'b0;
        #1;
        chk("arst_cnt", 64'(w_cnt_b), 64'd0);
        chk("arst_busy", 64'(w_rd_busy_b), 64'd0);
        chk("arst_x5", rdb(0), 64'd0);
        chk("arst_ready", 64'(w_iss_ready_b), 64'd1);
        #4;
        rst_sys_n_i = 1'b1;
        step();
        chk("post_cnt", 64'(w_cnt_n), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
